// File: rtl/data_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_slave
//  Description : Memory-side responder for the CPU data port SRAM-like
//                handshake (req/addr_ok/data_ok). Word-organised RAM with
//                byte-lane write strobes, one accept per cycle, and exactly
//                one in-order data_ok per accepted request after a fixed
//                LATENCY.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_sram_slave #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int             c_WORDS  = 1 << ADDR_W;
    localparam int             c_CNT_W  = $clog2(QDEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_QDEPTH = c_CNT_W'(QDEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    logic [31:0]        r_mem [c_WORDS];
    logic [LATENCY-1:0] r_valid;
    logic [31:0]        r_word [LATENCY];
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic [ADDR_W-1:0]  w_idx;
    logic               w_unused_ok;

    // Byte offset and upper address bits are ignored, so the index wraps
    // modulo the RAM size; size is informational only.
    assign w_idx       = addr[ADDR_W+1:2];
    assign w_unused_ok = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    // Acceptance depends on the outstanding count only, never on req.
    assign addr_ok  = !reset && (r_cnt != c_QDEPTH);
    assign w_accept = req && addr_ok;

    // RAM write port: only enabled lanes are updated; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Response delay line: stage 0 captures the read word at the accept
    // edge; write responses and bubbles carry zero so rdata needs no gating.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_word[i] <= '0;
            end
        end else begin
            r_valid[0] <= w_accept;
            r_word[0]  <= (w_accept && !wr) ? r_mem[w_idx] : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_word[i]  <= r_word[i-1];
            end
        end
    end

    assign data_ok = r_valid[LATENCY-1];
    assign rdata   = r_word[LATENCY-1];

    // Outstanding counter: +1 per accept, -1 per data_ok, net zero if both.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            case ({w_accept, data_ok})
                2'b10:   r_cnt <= r_cnt + c_ONE;
                2'b01:   r_cnt <= r_cnt - c_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_sram_slave
//  Description : Directed self-checking bench for data_sram_slave. Three
//                instances share the request inputs: A (LATENCY=2), B
//                (LATENCY=6) and C (LATENCY=4), all with QDEPTH=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_slave;

    logic        clk;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        addr_ok_a, data_ok_a;
    logic [31:0] rdata_a;
    logic        addr_ok_b, data_ok_b;
    logic [31:0] rdata_b;
    logic        addr_ok_c, data_ok_c;
    logic [31:0] rdata_c;

    int vectors = 0;
    int errors  = 0;

    data_sram_slave #(.ADDR_W(10), .LATENCY(2), .QDEPTH(4)) u_dut_a (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok_a), .data_ok(data_ok_a), .rdata(rdata_a)
    );

    data_sram_slave #(.ADDR_W(10), .LATENCY(6), .QDEPTH(4)) u_dut_b (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok_b), .data_ok(data_ok_b), .rdata(rdata_b)
    );

    data_sram_slave #(.ADDR_W(10), .LATENCY(4), .QDEPTH(4)) u_dut_c (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok_c), .data_ok(data_ok_c), .rdata(rdata_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive a request, then settle before any checks in this cycle.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        wstrb = s;
        size  = 2'd2;
        #1;
    endtask

    task automatic idle();
        req   = 1'b0;
        wr    = 1'b0;
        wstrb = 4'h0;
        #1;
    endtask

    task automatic idle_n(input int n);
        repeat (n) begin
            cyc();
            idle();
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0;
        wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_addr_ok", {31'b0, addr_ok_a}, 32'd0);
        chk("rst_data_ok", {31'b0, data_ok_a}, 32'd0);
        chk("rst_rdata",   rdata_a,            32'h0);
        cyc(); reset = 1'b0; idle();
        chk("post_rst_addr_ok", {31'b0, addr_ok_a}, 32'd1);

        // Basic write then read
        cyc(); issue(1'b1, 32'h100, 32'h12345678, 4'hF);
        chk("wr_addr_ok", {31'b0, addr_ok_a}, 32'd1);
        cyc(); issue(1'b0, 32'h100, 32'h0, 4'h0);
        chk("c1_no_data_ok", {31'b0, data_ok_a}, 32'd0);
        cyc(); idle();
        chk("wr_data_ok", {31'b0, data_ok_a}, 32'd1);
        chk("wr_rdata",   rdata_a,            32'h0);
        cyc(); idle();
        chk("rd_data_ok", {31'b0, data_ok_a}, 32'd1);
        chk("rd_rdata",   rdata_a,            32'h12345678);
        cyc(); idle();
        chk("rd_pulse_end", {31'b0, data_ok_a}, 32'd0);
        chk("rd_rdata_idle", rdata_a,           32'h0);

        // Byte lane write
        cyc(); issue(1'b1, 32'h102, 32'h00AB0000, 4'b0100);
        cyc(); issue(1'b0, 32'h100, 32'h0, 4'h0);
        cyc(); idle();
        cyc(); idle();
        chk("lane_rdata", rdata_a, 32'h12AB5678);

        // Write with no lanes enabled still responds, RAM unchanged
        cyc(); issue(1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000);
        cyc(); issue(1'b0, 32'h100, 32'h0, 4'h0);
        cyc(); idle();
        chk("nolane_data_ok", {31'b0, data_ok_a}, 32'd1);
        chk("nolane_rdata0",  rdata_a,            32'h0);
        cyc(); idle();
        chk("nolane_rdata", rdata_a, 32'h12AB5678);
        idle_n(8);

        // Back-to-back reads of preloaded words
        for (int i = 0; i < 4; i++) begin
            cyc(); issue(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
        end
        idle_n(8);
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i < 4) begin
                issue(1'b0, 32'(i * 4), 32'h0, 4'h0);
                chk("b2b_addr_ok", {31'b0, addr_ok_a}, 32'd1);
            end else begin
                idle();
            end
            chk("b2b_data_ok", {31'b0, data_ok_a}, (i >= 2) ? 32'd1 : 32'd0);
            chk("b2b_rdata",   rdata_a, (i >= 2) ? (32'hA0 + 32'(i - 2)) : 32'h0);
        end
        cyc(); idle();
        chk("b2b_end", {31'b0, data_ok_a}, 32'd0);
        idle_n(8);

        // Full condition on the LATENCY=6 instance, req held high
        for (int i = 0; i < 14; i++) begin
            cyc(); issue(1'b0, 32'h0, 32'h0, 4'h0);
            if (i <= 10) begin
                chk("full_addr_ok", {31'b0, addr_ok_b},
                    ((i < 4) || (i >= 7)) ? 32'd1 : 32'd0);
            end
            chk("full_data_ok", {31'b0, data_ok_b},
                (((i >= 6) && (i <= 9)) || (i == 13)) ? 32'd1 : 32'd0);
            if (i == 13) begin
                chk("full_5th_rdata", rdata_b, 32'hA0);
            end
        end
        idle_n(16);

        // Address wrap
        cyc(); issue(1'b1, 32'h1000, 32'h55, 4'hF);
        cyc(); issue(1'b0, 32'h0000, 32'h0, 4'h0);
        cyc(); idle();
        cyc(); idle();
        chk("wrap_data_ok", {31'b0, data_ok_a}, 32'd1);
        chk("wrap_rdata",   rdata_a,            32'h55);
        idle_n(16);

        // Reset mid-operation on the LATENCY=4 instance
        cyc(); issue(1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
        cyc(); issue(1'b0, 32'h0, 32'h0, 4'h0);
        cyc(); issue(1'b0, 32'h4, 32'h0, 4'h0);
        cyc(); reset = 1'b1; issue(1'b0, 32'h24, 32'h0, 4'h0);
        chk("mid_rst_addr_ok", {31'b0, addr_ok_c}, 32'd0);
        chk("mid_rst_data_ok", {31'b0, data_ok_c}, 32'd0);
        cyc(); reset = 1'b0; idle();
        chk("post_mid_rst_addr_ok", {31'b0, addr_ok_c}, 32'd1);
        chk("post_mid_rst_data_ok", {31'b0, data_ok_c}, 32'd0);
        for (int k = 5; k <= 8; k++) begin
            cyc(); idle();
            chk("discard_data_ok", {31'b0, data_ok_c}, 32'd0);
        end
        cyc(); issue(1'b0, 32'h20, 32'h0, 4'h0);
        idle_n(3);
        cyc(); idle();
        chk("persist_data_ok", {31'b0, data_ok_c}, 32'd1);
        chk("persist_rdata",   rdata_c,            32'hDEADBEEF);
        idle_n(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
